// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, controller
// states and instruction-field slice helpers.
package cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Register-field slots inside {op, rd, rs1, rs2}, counted from the LSB.
    localparam int FLD_RS2 = 0;
    localparam int FLD_RS1 = 1;
    localparam int FLD_RD  = 2;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Opcode sits above the three register fields of width aw.
    function automatic logic [2:0] inst_op(
        input logic [31:0] inst,
        input int          aw
    );
        return 3'(inst >> (3 * aw));
    endfunction

    // Register field at the given slot; caller truncates to its width.
    function automatic logic [7:0] inst_reg(
        input logic [31:0] inst,
        input int          aw,
        input int          slot
    );
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return 8'((inst >> (slot * aw)) & mask);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multicycle CPU core.
// Ports: i_op (opcode), i_a/i_b (operands), o_result, o_carry
// (carry-out for ADD, borrow for SUB, shifted-out MSB for SHL, else 0).
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        unique case (i_op)
            OP_ADD:  {o_carry, o_result} = {1'b0, i_a} + {1'b0, i_b};
            // Borrow appears as the wrapped top bit of the widened difference.
            OP_SUB:  {o_carry, o_result} = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  begin
                o_result = {i_a[DATA_W-2:0], 1'b0};
                o_carry  = i_a[DATA_W-1];
            end
            OP_MOV:  o_result = i_a;
            OP_HALT: o_result = '0;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_seq_core.sv
// Multicycle CPU core: LOAD -> EXEC -> OUTPUT -> HOLD controller with an
// inline register file and instruction memory.
// Ports: clk, rst (async active-low); host load port inst_wr_en/inst_addr/
// inst_in, reg_wr_en/reg_addr/reg_in; inst_count + start; status busy/done;
// output stream out_valid/out_ready/out_addr/out_data.
// Option: define CPU_FLAGS_EN to add flag_z/flag_c outputs.
module cpu_seq_core
    import cpu_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int NREG       = 4,
    parameter  int IMEM_DEPTH = 16,
    localparam int REG_AW     = $clog2(NREG),
    localparam int PC_W       = $clog2(IMEM_DEPTH),
    localparam int INST_W     = 3 + 3 * REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_wr_en,
    input  logic [PC_W-1:0]   inst_addr,
    input  logic [INST_W-1:0] inst_in,
    input  logic              reg_wr_en,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_in,
    input  logic [PC_W:0]     inst_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_addr,
`ifdef CPU_FLAGS_EN
    output logic              flag_z,
    output logic              flag_c,
`endif
    output logic [DATA_W-1:0] out_data
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W:0]       r_count;
    logic [REG_AW-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_rf   [NREG];
    logic [INST_W-1:0]   r_imem [IMEM_DEPTH];

    logic [INST_W-1:0]   w_inst;
    logic [2:0]          w_op;
    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_rs1;
    logic [REG_AW-1:0]   w_rs2;
    logic [DATA_W-1:0]   w_result;
    logic                w_alu_carry;
    logic [PC_W:0]       w_pc_inc;
    logic                w_last_exec;
    logic                w_beat;
    logic                w_last_beat;

    assign w_inst = r_imem[r_pc];
    assign w_op   = inst_op(32'(w_inst), REG_AW);
    assign w_rd   = REG_AW'(inst_reg(32'(w_inst), REG_AW, FLD_RD));
    assign w_rs1  = REG_AW'(inst_reg(32'(w_inst), REG_AW, FLD_RS1));
    assign w_rs2  = REG_AW'(inst_reg(32'(w_inst), REG_AW, FLD_RS2));

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (r_rf[w_rs1]),
        .i_b      (r_rf[w_rs2]),
        .o_result (w_result),
        .o_carry  (w_alu_carry)
    );

    // Run ends on HALT, on reaching the latched count, or at the last slot.
    assign w_pc_inc    = {1'b0, r_pc} + {{PC_W{1'b0}}, 1'b1};
    assign w_last_exec = (w_op == OP_HALT)
                      || (w_pc_inc == r_count)
                      || (r_pc == PC_W'(IMEM_DEPTH - 1));

    assign w_beat      = (r_state == ST_OUTPUT) && out_ready;
    assign w_last_beat = (r_out_addr == REG_AW'(NREG - 1));

    assign busy      = (r_state == ST_EXEC) || (r_state == ST_OUTPUT);
    assign done      = (r_state == ST_HOLD);
    assign out_valid = (r_state == ST_OUTPUT);
    assign out_addr  = r_out_addr;
    assign out_data  = r_rf[r_out_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_LOAD: begin
                if (start) begin
                    w_state_nxt = (inst_count == '0) ? ST_OUTPUT
                                                     : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_last_exec) w_state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (w_beat && w_last_beat) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_count    <= '0;
            r_out_addr <= '0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            for (int i = 0; i < IMEM_DEPTH; i++) r_imem[i] <= '0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (inst_wr_en) r_imem[inst_addr] <= inst_in;
                    if (reg_wr_en) r_rf[reg_addr] <= reg_in;
                    if (start) begin
                        r_count <= inst_count;
                        r_pc    <= '0;
                    end
                end
                ST_EXEC: begin
                    if (w_op != OP_HALT) r_rf[w_rd] <= w_result;
                    r_pc <= r_pc + 1'b1;
                end
                ST_OUTPUT: begin
                    // Index wraps back to 0 after the final beat.
                    if (out_ready) r_out_addr <= r_out_addr + 1'b1;
                end
                ST_HOLD: begin
                    if (start) r_pc <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_FLAGS_EN
    logic r_flag_z;
    logic r_flag_c;
    logic w_flag_op;

    assign w_flag_op = (w_op == OP_ADD) || (w_op == OP_SUB)
                    || (w_op == OP_SHL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (r_state == ST_LOAD && start) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (r_state == ST_EXEC && w_flag_op) begin
            r_flag_z <= (w_result == '0);
            r_flag_c <= w_alu_carry;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_c = r_flag_c;
`else
    logic w_unused;
    assign w_unused = w_alu_carry;
`endif

endmodule

// File: tb/tb_cpu_seq_core.sv
// Directed self-checking bench for cpu_seq_core: expected output beats are
// queued when a run is launched and compared as the core streams them.
module tb_cpu_seq_core;
    import cpu_pkg::*;

    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int DEPTH  = 16;
    localparam int REG_AW = 2;
    localparam int PC_W   = 4;
    localparam int INST_W = 3 + 3 * REG_AW;
    localparam int ENT_W  = REG_AW + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              inst_wr_en = 1'b0;
    logic [PC_W-1:0]   inst_addr = '0;
    logic [INST_W-1:0] inst_in = '0;
    logic              reg_wr_en = 1'b0;
    logic [REG_AW-1:0] reg_addr = '0;
    logic [DATA_W-1:0] reg_in = '0;
    logic [PC_W:0]     inst_count = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [REG_AW-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
`ifdef CPU_FLAGS_EN
    logic              flag_z;
    logic              flag_c;
`endif

    int errors = 0;
    int checks = 0;
    logic [ENT_W-1:0] sb[$];

    always #5 clk = ~clk;

    cpu_seq_core #(
        .DATA_W     (DATA_W),
        .NREG       (NREG),
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_wr_en (inst_wr_en),
        .inst_addr  (inst_addr),
        .inst_in    (inst_in),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_in     (reg_in),
        .inst_count (inst_count),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
`ifdef CPU_FLAGS_EN
        .flag_z     (flag_z),
        .flag_c     (flag_c),
`endif
        .out_data   (out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INST_W-1:0] enc(input logic [2:0] op,
        input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_in    = d;
        tick();
        reg_wr_en = 1'b0;
    endtask

    task automatic wr_inst(input logic [3:0] a, input logic [INST_W-1:0] w);
        inst_wr_en = 1'b1;
        inst_addr  = a;
        inst_in    = w;
        tick();
        inst_wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] cnt);
        inst_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic exp4(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        sb.push_back({2'd0, d0});
        sb.push_back({2'd1, d1});
        sb.push_back({2'd2, d2});
        sb.push_back({2'd3, d3});
    endtask

    // Counts EXEC cycles until the first output beat is offered.
    task automatic run_exec(input string tag, input int n_exp);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (busy) n++;
        end
        check({tag, " out_valid seen"}, 32'(seen), 32'd1);
        check({tag, " exec cycles"}, n, n_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int stall_beat,
                         input int stall_n);
        int beats = 0;
        int held = 0;
        int guard = 0;
        logic [ENT_W-1:0] e;
        while (beats < NREG && guard < 200) begin
            out_ready = !(beats == stall_beat && held < stall_n);
            @(negedge clk);
            if (out_valid) begin
                e = (sb.size() != 0) ? sb[0] : 'x;
                if (out_ready) begin
                    check({tag, " addr"}, out_addr, e[DATA_W +: REG_AW]);
                    check({tag, " data"}, out_data, e[DATA_W-1:0]);
                    if (sb.size() != 0) void'(sb.pop_front());
                    beats++;
                end else begin
                    held++;
                    check({tag, " stall addr"}, out_addr, stall_beat);
                    check({tag, " stall data"}, out_data, e[DATA_W-1:0]);
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        check({tag, " beats"}, beats, NREG);
        check({tag, " sb empty"}, sb.size(), 0);
        @(negedge clk);
        check({tag, " done"}, done, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " valid off"}, out_valid, 1'b0);
    endtask

    initial begin
        // T1: reset values, reset mid-EXEC, all-zero rf via OUTPUT.
        #2;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst valid", out_valid, 1'b0);
        check("rst addr", out_addr, 2'd0);
        tick();
        rst = 1'b1;
        tick();
        wr_reg(2'd0, 8'd5);
        wr_inst(4'd0, enc(OP_ADD, 2'd1, 2'd0, 2'd0));
        pulse_start(5'd3);
        check("t1 busy exec", busy, 1'b1);
        tick();
        rst = 1'b0;
        #2;
        check("t1 mid busy", busy, 1'b0);
        check("t1 mid done", done, 1'b0);
        check("t1 mid valid", out_valid, 1'b0);
        check("t1 mid addr", out_addr, 2'd0);
        tick();
        rst = 1'b1;
        tick();
        exp4(8'd0, 8'd0, 8'd0, 8'd0);
        pulse_start(5'd0);
        run_exec("t1", 0);
        drain("t1", -1, 0);

        // T2: ADD with carry discarded, single instruction.
        pulse_start(5'd0);
        check("t2 load done", done, 1'b0);
        wr_reg(2'd0, 8'd200);
        wr_reg(2'd1, 8'd100);
        wr_inst(4'd0, enc(OP_ADD, 2'd2, 2'd0, 2'd1));
        exp4(8'd200, 8'd100, 8'd44, 8'd0);
        pulse_start(5'd1);
        run_exec("t2", 1);
        drain("t2", -1, 0);

        // T3/T4: HALT ends early; backpressure on beat 1.
        pulse_start(5'd0);
        wr_inst(4'd0, enc(OP_SUB, 2'd3, 2'd1, 2'd0));
        wr_inst(4'd1, enc(OP_XOR, 2'd0, 2'd0, 2'd0));
        wr_inst(4'd2, enc(OP_HALT, 2'd1, 2'd1, 2'd1));
        wr_inst(4'd3, enc(OP_ADD, 2'd1, 2'd1, 2'd1));
        exp4(8'd0, 8'd100, 8'd44, 8'd156);
        pulse_start(5'd4);
        run_exec("t3", 3);
        drain("t4", 1, 3);

        // T5a: rerun without reload; writes during EXEC/OUTPUT ignored.
        pulse_start(5'd0);
        exp4(8'd0, 8'd100, 8'd44, 8'd100);
        pulse_start(5'd4);
        reg_wr_en  = 1'b1;
        reg_addr   = 2'd1;
        reg_in     = 8'd77;
        inst_wr_en = 1'b1;
        inst_addr  = 4'd2;
        inst_in    = enc(OP_ADD, 2'd0, 2'd1, 2'd1);
        run_exec("t5 rerun", 3);
        drain("t5 rerun", 2, 2);
        reg_wr_en  = 1'b0;
        inst_wr_en = 1'b0;

        // T5b: count=0 goes straight to OUTPUT, rf unchanged.
        pulse_start(5'd0);
        exp4(8'd0, 8'd100, 8'd44, 8'd100);
        pulse_start(5'd0);
        run_exec("t5 zero", 0);
        drain("t5 zero", -1, 0);

`ifdef CPU_FLAGS_EN
        // T6: SHL of 0x80 sets z and c; AND after it leaves them alone.
        pulse_start(5'd0);
        wr_reg(2'd0, 8'h80);
        wr_reg(2'd1, 8'hFF);
        wr_inst(4'd0, enc(OP_SHL, 2'd2, 2'd0, 2'd0));
        wr_inst(4'd1, enc(OP_AND, 2'd3, 2'd1, 2'd1));
        wr_inst(4'd2, enc(OP_HALT, 2'd0, 2'd0, 2'd0));
        exp4(8'h80, 8'hFF, 8'h00, 8'hFF);
        pulse_start(5'd3);
        check("t6 z cleared", flag_z, 1'b0);
        check("t6 c cleared", flag_c, 1'b0);
        run_exec("t6", 3);
        check("t6 flag_z", flag_z, 1'b1);
        check("t6 flag_c", flag_c, 1'b1);
        drain("t6", -1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
